// File: rtl/axi_stream_2_ppfifo.sv
// AXI Stream ingress into the write side of a ping-pong FIFO.
// One ppfifo buffer is filled per activation and released on full or on an accepted tlast.
module axi_stream_2_ppfifo #(
    parameter int DATA_WIDTH    = 32,
    parameter bit FLUSH_ON_LAST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_axi_valid,
    output logic                  o_axi_ready,
    input  logic [DATA_WIDTH-1:0] i_axi_data,
    input  logic [3:0]            i_axi_keep,
    input  logic                  i_axi_last,

    input  logic [1:0]            i_ppfifo_rdy,
    output logic [1:0]            o_ppfifo_act,
    input  logic [23:0]           i_ppfifo_size,
    output logic                  o_ppfifo_stb,
    output logic [DATA_WIDTH-1:0] o_ppfifo_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [1:0]            act_reg, act_next;
    logic                  stb_reg, stb_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [23:0]           count_reg, count_next;
    logic [23:0]           max_reg, max_next;
    logic                  handshake;

    // Byte enables are deliberately ignored: every beat lands as a full word.
    logic unused_keep;
    assign unused_keep = ^i_axi_keep;

    // Ready depends on registers only, so there is no valid-to-ready path.
    assign o_axi_ready   = (state_reg == WRITE) && (count_reg < max_reg);
    assign handshake     = i_axi_valid && o_axi_ready;

    assign o_ppfifo_act  = act_reg;
    assign o_ppfifo_stb  = stb_reg;
    assign o_ppfifo_data = data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            act_reg   <= 2'b00;
            stb_reg   <= 1'b0;
            data_reg  <= '0;
            count_reg <= 24'd0;
            max_reg   <= 24'd0;
        end else begin
            state_reg <= state_next;
            act_reg   <= act_next;
            stb_reg   <= stb_next;
            data_reg  <= data_next;
            count_reg <= count_next;
            max_reg   <= max_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        act_next   = act_reg;
        stb_next   = 1'b0;
        data_next  = data_reg;
        count_next = count_reg;
        max_next   = max_reg;

        case (state_reg)
            IDLE: begin
                // A zero-sized buffer can never take a word, so it is never activated.
                if ((i_ppfifo_rdy != 2'b00) && (i_ppfifo_size != 24'd0)) begin
                    act_next   = i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
                    max_next   = i_ppfifo_size;
                    count_next = 24'd0;
                    state_next = WRITE;
                end
            end

            WRITE: begin
                if (handshake) begin
                    stb_next   = 1'b1;
                    data_next  = i_axi_data;
                    count_next = count_reg + 24'd1;
                    if ((count_next == max_reg) || (i_axi_last && FLUSH_ON_LAST))
                        state_next = RELEASE;
                end
            end

            RELEASE: begin
                // The final strobe is on the bus this cycle; act drops one cycle after it.
                act_next   = 2'b00;
                state_next = IDLE;
            end

            default: begin
                act_next   = 2'b00;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_stream_2_ppfifo.sv
// Directed self-checking bench for axi_stream_2_ppfifo.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_axi_stream_2_ppfifo;

    logic        clk = 1'b0;
    logic        rst;

    logic        axi_valid, axi_last;
    logic [31:0] axi_data;
    logic [1:0]  ppfifo_rdy;
    logic [23:0] ppfifo_size;
    logic        axi_ready, ppfifo_stb;
    logic [1:0]  ppfifo_act;
    logic [31:0] ppfifo_data;

    // Second instance with tlast flushing disabled.
    logic        nf_valid, nf_last;
    logic [31:0] nf_data;
    logic [1:0]  nf_rdy;
    logic [23:0] nf_size;
    logic        nf_ready, nf_stb;
    logic [1:0]  nf_act;
    logic [31:0] nf_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_stream_2_ppfifo #(.DATA_WIDTH(32), .FLUSH_ON_LAST(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_axi_valid   (axi_valid),
        .o_axi_ready   (axi_ready),
        .i_axi_data    (axi_data),
        .i_axi_keep    (4'hF),
        .i_axi_last    (axi_last),
        .i_ppfifo_rdy  (ppfifo_rdy),
        .o_ppfifo_act  (ppfifo_act),
        .i_ppfifo_size (ppfifo_size),
        .o_ppfifo_stb  (ppfifo_stb),
        .o_ppfifo_data (ppfifo_data)
    );

    axi_stream_2_ppfifo #(.DATA_WIDTH(32), .FLUSH_ON_LAST(1'b0)) dut_nf (
        .clk           (clk),
        .rst           (rst),
        .i_axi_valid   (nf_valid),
        .o_axi_ready   (nf_ready),
        .i_axi_data    (nf_data),
        .i_axi_keep    (4'h0),
        .i_axi_last    (nf_last),
        .i_ppfifo_rdy  (nf_rdy),
        .o_ppfifo_act  (nf_act),
        .i_ppfifo_size (nf_size),
        .o_ppfifo_stb  (nf_stb),
        .o_ppfifo_data (nf_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Present one beat, wait (bounded) for its acceptance, then check the resulting strobe.
    task automatic send(input logic [31:0] d, input logic l);
        logic acc;
        acc       = 1'b0;
        axi_valid = 1'b1;
        axi_data  = d;
        axi_last  = l;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = axi_ready;
            @(negedge clk);
        end
        if (acc) begin
            check("beat_stb", {31'd0, ppfifo_stb}, 32'd1);
            check("beat_data", ppfifo_data, d);
        end else begin
            check("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_act(input logic [1:0] exp);
        for (int i = 0; i < 10 && ppfifo_act == 2'b00; i++) @(negedge clk);
        check("act_select", {30'd0, ppfifo_act}, {30'd0, exp});
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        axi_valid = 1'b0; axi_last = 1'b0; axi_data = '0;
        ppfifo_rdy = 2'b00; ppfifo_size = 24'd0;
        nf_valid = 1'b0; nf_last = 1'b0; nf_data = '0; nf_rdy = 2'b00; nf_size = 24'd0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_act",   {30'd0, ppfifo_act}, 32'd0);
        check("rst_stb",   {31'd0, ppfifo_stb}, 32'd0);
        check("rst_data",  ppfifo_data, 32'd0);
        check("rst_ready", {31'd0, axi_ready}, 32'd0);

        // Single full buffer
        rst = 1'b0; ppfifo_size = 24'd4; ppfifo_rdy = 2'b01;
        wait_act(2'b01);
        check("full_ready_open", {31'd0, axi_ready}, 32'd1);
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        send(32'h33, 1'b0);
        send(32'h44, 1'b0);
        check("full_ready_low", {31'd0, axi_ready}, 32'd0);
        check("full_act_held", {30'd0, ppfifo_act}, 32'd1);
        axi_valid = 1'b0; ppfifo_rdy = 2'b00;
        @(negedge clk);
        check("full_act_drop", {30'd0, ppfifo_act}, 32'd0);
        check("full_no_extra_stb", {31'd0, ppfifo_stb}, 32'd0);

        // Early tlast with flushing enabled
        ppfifo_size = 24'd8; ppfifo_rdy = 2'b01;
        wait_act(2'b01);
        send(32'hA1, 1'b0);
        send(32'hA2, 1'b0);
        send(32'hA3, 1'b1);
        check("last_ready_low", {31'd0, axi_ready}, 32'd0);
        axi_valid = 1'b0; axi_last = 1'b0; ppfifo_rdy = 2'b00;
        @(negedge clk);
        check("last_act_drop", {30'd0, ppfifo_act}, 32'd0);
        check("last_no_4th_stb", {31'd0, ppfifo_stb}, 32'd0);

        // Early tlast with flushing disabled: buffer stays open
        nf_rdy = 2'b01; nf_size = 24'd8;
        repeat (2) @(negedge clk);
        nf_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nf_data = 32'hB1 + i;
            nf_last = (i == 2);
            @(negedge clk);
        end
        check("nf_third_data", nf_out, 32'hB3);
        nf_valid = 1'b0; nf_last = 1'b0;
        @(negedge clk);
        check("nf_act_held", {30'd0, nf_act}, 32'd1);
        check("nf_ready_held", {31'd0, nf_ready}, 32'd1);

        // Ping-pong alternation
        ppfifo_size = 24'd2; ppfifo_rdy = 2'b11;
        wait_act(2'b01);
        send(32'h01, 1'b0);
        send(32'h02, 1'b0);
        ppfifo_rdy = 2'b10; axi_valid = 1'b0;
        @(negedge clk);
        check("pp_act_drop", {30'd0, ppfifo_act}, 32'd0);
        wait_act(2'b10);
        send(32'h03, 1'b0);
        send(32'h04, 1'b0);
        ppfifo_rdy = 2'b00; axi_valid = 1'b0;
        @(negedge clk);
        check("pp_act_drop2", {30'd0, ppfifo_act}, 32'd0);

        // Backpressure, bubbles and a rdy=00 window
        ppfifo_size = 24'd16; ppfifo_rdy = 2'b01;
        wait_act(2'b01);
        for (int i = 0; i < 4; i++) begin
            send(32'hC0 + i, (i == 3));
            axi_valid = 1'b0; axi_last = 1'b0;
            if (i == 3) ppfifo_rdy = 2'b00;
            @(negedge clk);
            check("bubble_no_stb", {31'd0, ppfifo_stb}, 32'd0);
        end
        axi_valid = 1'b1; axi_data = 32'h55; axi_last = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axi_ready || ppfifo_act != 2'b00 || ppfifo_stb) bad++;
        end
        check("rdy00_window_quiet", bad, 32'd0);
        ppfifo_rdy = 2'b01;
        send(32'h55, 1'b1);
        ppfifo_rdy = 2'b00; axi_valid = 1'b0; axi_last = 1'b0;
        @(negedge clk);
        check("held_beat_released", {30'd0, ppfifo_act}, 32'd0);

        // Zero size
        ppfifo_rdy = 2'b01; ppfifo_size = 24'd0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (axi_ready || ppfifo_act != 2'b00) bad++;
        end
        check("zero_size_idle", bad, 32'd0);
        ppfifo_size = 24'd8;
        wait_act(2'b01);

        // Reset mid-block
        send(32'h61, 1'b0);
        send(32'h62, 1'b0);
        send(32'h63, 1'b0);
        axi_valid = 1'b1; axi_data = 32'h64; rst = 1'b1;
        @(negedge clk);
        check("mid_rst_act",   {30'd0, ppfifo_act}, 32'd0);
        check("mid_rst_stb",   {31'd0, ppfifo_stb}, 32'd0);
        check("mid_rst_ready", {31'd0, axi_ready}, 32'd0);
        rst = 1'b0; axi_valid = 1'b0;
        wait_act(2'b01);
        for (int i = 0; i < 8; i++) send(32'h70 + i, 1'b0);
        check("post_rst_full", {31'd0, axi_ready}, 32'd0);
        axi_valid = 1'b0; ppfifo_rdy = 2'b00;
        @(negedge clk);
        check("post_rst_act_drop", {30'd0, ppfifo_act}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
